muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Sequences the multiply and divide units that feed the HI/LO register pair. Accepts one-cycle start requests from the control unit and launches the selected unit. Waits for that unit's completion, then drives the HI/LO write enables and the MorDHi/MorDLo mux selects for exactly one cycle. Flags divide-by-zero and unit timeouts as exceptions for the control unit, and reports busy so the control unit can stall.

## Interface
Parameters:
- TIMEOUT, 64: maximum number of RUN cycles to wait for a unit's done; must be ≥ 2.
- CNT_W, $clog2(TIMEOUT): width of the watchdog counter.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_mult  in  1  one-cycle request for a mult (A×B).
- start_div  in  1  one-cycle request for a div (A/B).
- divisor  in  32  RegB output; sampled when start_div is accepted.
- mult_done  in  1  multiplier result valid.
- div_done  in  1  divider result valid.
- mult_start  out  1  one-cycle launch pulse to the multiplier.
- div_start  out  1  one-cycle launch pulse to the divider.
- busy  out  1  operation in progress; the control unit stalls while this is high.
- hi_write  out  1  HI register write enable.
- lo_write  out  1  LO register write enable.
- mordhi_sel  out  1  MorDHi mux select: 0 = mult, 1 = div.
- mordlo_sel  out  1  MorDLo mux select: 0 = mult, 1 = div.
- op_done  out  1  one-cycle pulse: HI/LO written.
- div0_exc  out  1  one-cycle pulse: divide-by-zero.
- timeout_exc  out  1  one-cycle pulse: unit never signalled done.

## Operation
- States: IDLE, MULT_RUN, DIV_RUN, WRITE, EXC.
- IDLE:
  - start_mult → MULT_RUN.
  - start_div with divisor ≠ 0 → DIV_RUN.
  - start_div with divisor == 0 → EXC with cause = div0.
  - If start_mult and start_div are high together, mult wins and div is dropped.
- Entering MULT_RUN or DIV_RUN:
  - The watchdog counter clears to 0.
  - The matching launch pulse (mult_start or div_start) is high for the first RUN cycle only.
- In RUN:
  - The matching done input → WRITE.
  - Otherwise the counter increments each cycle.
  - If the counter equals TIMEOUT-1 without done → EXC with cause = timeout.
  - done takes priority over timeout in the same cycle.
  - The non-matching done input is ignored.
- WRITE (one cycle): hi_write = lo_write = op_done = 1, then → IDLE.
- EXC (one cycle): div0_exc or timeout_exc = 1 according to the latched cause, then → IDLE. HI/LO are never written.
- mordhi_sel and mordlo_sel are registered. They are set to the accepted op type (0 mult, 1 div) when a start is accepted and held until the next accepted start.
- start_* inputs are ignored in every state except IDLE.
- done inputs arriving in IDLE, WRITE or EXC are ignored.
- All outputs are registered, decoded from the state and the latched op/cause, so they are glitch-free.

## Timing
- Reset (asynchronous, low): state = IDLE, counter = 0, and every output = 0 (selects = 0 = mult). Any in-flight operation is abandoned and no HI/LO write occurs. After release, the first edge samples start_* normally.
- busy is high from the cycle after an accepted start through the WRITE/EXC cycle inclusive. busy is low in IDLE.
- Latency with done first seen N cycles after the launch-pulse cycle (N ≥ 0):
  - Launch pulse at cycle S+1, where S is the start cycle.
  - WRITE at cycle S+N+2.
  - busy is high for N+2 cycles.
- Divide-by-zero: EXC at cycle S+1. busy and div0_exc are high for that one cycle only.
- Timeout: the RUN phase lasts exactly TIMEOUT cycles, then timeout_exc pulses for one cycle.
- Back-to-back operation: a new start is accepted at the earliest in the first IDLE cycle after WRITE/EXC.

## Structure
- Shared package muldiv_pkg:
  - state enum (IDLE, MULT_RUN, DIV_RUN, WRITE, EXC);
  - MORD_MULT = 1'b0 and MORD_DIV = 1'b1 select constants;
  - cause enum (CAUSE_DIV0, CAUSE_TIMEOUT).
- One sub-module, muldiv_watchdog: counter with clear/enable inputs and an expired output at TIMEOUT-1, on the same asynchronous active-low reset.
- The FSM and output registers live in muldiv_sequencer.

## Test plan
- Mult: pulse start_mult at cycle 0, raise mult_done at cycle 33 → mult_start high at cycle 1 only; hi_write = lo_write = op_done = 1 at cycle 34; mordhi_sel = mordlo_sel = 0; busy high for cycles 1–34.
- Div with divisor = 7, div_done at cycle 5 → div_start at cycle 1; selects = 1; WRITE at cycle 6; no exception.
- Div with divisor = 0 → no div_start; div0_exc and busy high at cycle 1 only; hi_write never asserted.
- TIMEOUT = 64, mult with no done → timeout_exc at cycle 65; no HI/LO write. Repeat with mult_done at cycle 64 → WRITE at cycle 65 and no exception.
- start_mult and start_div in the same cycle → mult path only. A start_div pulse during MULT_RUN is ignored.
- Drop reset low mid-MULT_RUN (cycle 10) → all outputs 0 immediately; a mult_done afterward gives no write. A new start after reset release runs normally.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package muldiv_pkg;

   // Sequencer states: launch, wait for the unit, then one write or exception cycle
   typedef enum logic [2:0] {
      IDLE,
      MULT_RUN,
      DIV_RUN,
      WRITE,
      EXC
   } state_t;

   // MorDHi/MorDLo mux selects
   localparam logic MORD_MULT = 1'b0;
   localparam logic MORD_DIV  = 1'b1;

   // Reason an operation ended in the exception state
   typedef enum logic {
      CAUSE_DIV0,
      CAUSE_TIMEOUT
   } cause_t;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the control unit / mult-div units and the sequencer.
interface muldiv_sequencer_if;

   logic        start_mult;
   logic        start_div;
   logic [31:0] divisor;
   logic        mult_done;
   logic        div_done;
   logic        mult_start;
   logic        div_start;
   logic        busy;
   logic        hi_write;
   logic        lo_write;
   logic        mordhi_sel;
   logic        mordlo_sel;
   logic        op_done;
   logic        div0_exc;
   logic        timeout_exc;

   // Control-unit / unit side: issues requests and completions
   modport master (
      output start_mult, start_div, divisor, mult_done, div_done,
      input  mult_start, div_start, busy, hi_write, lo_write,
             mordhi_sel, mordlo_sel, op_done, div0_exc, timeout_exc
   );

   // Sequencer side
   modport slave (
      input  start_mult, start_div, divisor, mult_done, div_done,
      output mult_start, div_start, busy, hi_write, lo_write,
             mordhi_sel, mordlo_sel, op_done, div0_exc, timeout_exc
   );

endinterface

// File: rtl/muldiv_sequencer_watchdog.sv
// Watchdog counter: counts RUN cycles and flags when the last allowed cycle is reached.
module muldiv_watchdog #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = $clog2(TIMEOUT)
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Clear wins over increment so a fresh launch always starts counting from zero
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Counter register, cleared asynchronously by the active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences the mult/div units feeding HI/LO: launch, wait for done, write or raise an exception.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = $clog2(TIMEOUT)
) (
   input  logic                clk,
   input  logic                reset,
   muldiv_sequencer_if.slave   bus
);

   state_t state_q, state_d;
   cause_t cause_q, cause_d;
   logic   mord_q, mord_d;

   logic   wd_clear;
   logic   wd_enable;
   logic   wd_expired;

   logic   mult_start_q, mult_start_d;
   logic   div_start_q, div_start_d;
   logic   busy_q, busy_d;
   logic   write_q, write_d;
   logic   div0_q, div0_d;
   logic   timeout_q, timeout_d;

   muldiv_watchdog #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

   // Next-state logic: accept starts only in IDLE, mult beats div, done beats timeout
   always_comb begin
      state_d   = state_q;
      cause_d   = cause_q;
      mord_d    = mord_q;
      wd_clear  = 1'b0;
      wd_enable = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start_mult) begin
               state_d  = MULT_RUN;
               mord_d   = MORD_MULT;
               wd_clear = 1'b1;
            end else if (bus.start_div) begin
               mord_d = MORD_DIV;
               if (bus.divisor != 32'd0) begin
                  state_d  = DIV_RUN;
                  wd_clear = 1'b1;
               end else begin
                  state_d = EXC;
                  cause_d = CAUSE_DIV0;
               end
            end
         end
         MULT_RUN: begin
            if (bus.mult_done) begin
               state_d = WRITE;
            end else if (wd_expired) begin
               state_d = EXC;
               cause_d = CAUSE_TIMEOUT;
            end else begin
               wd_enable = 1'b1;
            end
         end
         DIV_RUN: begin
            if (bus.div_done) begin
               state_d = WRITE;
            end else if (wd_expired) begin
               state_d = EXC;
               cause_d = CAUSE_TIMEOUT;
            end else begin
               wd_enable = 1'b1;
            end
         end
         WRITE:   state_d = IDLE;
         EXC:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode from the upcoming state so every output comes straight from a flop
   always_comb begin
      mult_start_d = (state_q == IDLE) && (state_d == MULT_RUN);
      div_start_d  = (state_q == IDLE) && (state_d == DIV_RUN);
      busy_d       = (state_d != IDLE);
      write_d      = (state_d == WRITE);
      div0_d       = (state_d == EXC) && (cause_d == CAUSE_DIV0);
      timeout_d    = (state_d == EXC) && (cause_d == CAUSE_TIMEOUT);
   end

   // State, latched op/cause and output registers; reset abandons any operation
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cause_q      <= CAUSE_DIV0;
         mord_q       <= MORD_MULT;
         mult_start_q <= 1'b0;
         div_start_q  <= 1'b0;
         busy_q       <= 1'b0;
         write_q      <= 1'b0;
         div0_q       <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cause_q      <= cause_d;
         mord_q       <= mord_d;
         mult_start_q <= mult_start_d;
         div_start_q  <= div_start_d;
         busy_q       <= busy_d;
         write_q      <= write_d;
         div0_q       <= div0_d;
         timeout_q    <= timeout_d;
      end
   end

   assign bus.mult_start  = mult_start_q;
   assign bus.div_start   = div_start_q;
   assign bus.busy        = busy_q;
   assign bus.hi_write    = write_q;
   assign bus.lo_write    = write_q;
   assign bus.op_done     = write_q;
   assign bus.mordhi_sel  = mord_q;
   assign bus.mordlo_sel  = mord_q;
   assign bus.div0_exc    = div0_q;
   assign bus.timeout_exc = timeout_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: random ops, expected events queued, monitor compares.
module tb_muldiv_sequencer;

   localparam int TIMEOUT = 64;

   localparam int EV_WRITE   = 0;
   localparam int EV_DIV0    = 1;
   localparam int EV_TIMEOUT = 2;

   typedef struct {
      int   kind;
      logic sel;
      int   cyc;
   } ev_t;

   typedef struct {
      logic is_div;
      int   cyc;
   } launch_t;

   logic clk;
   logic reset;
   int   cycle;
   int   vectors;
   int   miscompares;

   ev_t     ev_q[$];
   launch_t launch_q[$];
   int      busy_q[$];

   muldiv_sequencer_if bus ();

   muldiv_sequencer #(
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle number, advanced on every rising edge
   initial cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic check_output(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation starting in the current cycle and play the unit side until it ends.
   // kind: 0 mult, 1 div (nonzero), 2 div by zero, 3 both starts together.
   // n: cycles after the launch cycle before done is raised; n >= TIMEOUT means never.
   task automatic apply_stimulus(input int kind, input int n, input bit stray);
      int          s;
      int          e;
      bit          is_div;
      bit          div0;
      logic [31:0] dv;
      ev_t         ev;
      launch_t     ln;

      s      = cycle;
      is_div = (kind == 1) || (kind == 2);
      div0   = (kind == 2);
      if (div0) begin
         dv = 32'd0;
      end else begin
         dv = $urandom();
         if (is_div && dv == 32'd0) dv = 32'd1;
      end

      if (div0) begin
         ev.kind = EV_DIV0; ev.sel = 1'b1; ev.cyc = s + 1;
         busy_q.push_back(1);
      end else begin
         ln.is_div = is_div; ln.cyc = s + 1;
         launch_q.push_back(ln);
         ev.sel = is_div;
         if (n < TIMEOUT) begin
            ev.kind = EV_WRITE; ev.cyc = s + n + 2;
            busy_q.push_back(n + 2);
         end else begin
            ev.kind = EV_TIMEOUT; ev.cyc = s + TIMEOUT + 1;
            busy_q.push_back(TIMEOUT + 1);
         end
      end
      ev_q.push_back(ev);
      e = ev.cyc;

      bus.start_mult = (kind == 0) || (kind == 3);
      bus.start_div  = (kind != 0);
      bus.divisor    = dv;
      next_cycle();

      while (cycle <= e) begin
         bus.start_mult = 1'b0;
         bus.start_div  = 1'b0;
         bus.mult_done  = 1'b0;
         bus.div_done   = 1'b0;
         bus.divisor    = $urandom();
         if (!div0 && n < TIMEOUT && cycle == s + 1 + n) begin
            if (is_div) bus.div_done = 1'b1;
            else        bus.mult_done = 1'b1;
         end
         if (stray && !div0 && cycle == s + 2 && cycle < e) begin
            if (is_div) begin
               bus.start_mult = 1'b1;
               bus.mult_done  = 1'b1;
            end else begin
               bus.start_div = 1'b1;
               bus.div_done  = 1'b1;
            end
         end
         next_cycle();
      end
      bus.start_mult = 1'b0;
      bus.start_div  = 1'b0;
      bus.mult_done  = 1'b0;
      bus.div_done   = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_output({tag, "_busy"},        int'(bus.busy),        0);
      check_output({tag, "_mult_start"},  int'(bus.mult_start),  0);
      check_output({tag, "_div_start"},   int'(bus.div_start),   0);
      check_output({tag, "_hi_write"},    int'(bus.hi_write),    0);
      check_output({tag, "_lo_write"},    int'(bus.lo_write),    0);
      check_output({tag, "_op_done"},     int'(bus.op_done),     0);
      check_output({tag, "_div0_exc"},    int'(bus.div0_exc),    0);
      check_output({tag, "_timeout_exc"}, int'(bus.timeout_exc), 0);
      check_output({tag, "_mordhi_sel"},  int'(bus.mordhi_sel),  0);
      check_output({tag, "_mordlo_sel"},  int'(bus.mordlo_sel),  0);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents an event, launch or busy window
   ev_t     mon_ev;
   launch_t mon_ln;
   int      mon_busy_len = 0;
   int      mon_busy_exp;

   always @(negedge clk) begin
      if (bus.hi_write || bus.lo_write || bus.op_done || bus.div0_exc || bus.timeout_exc) begin
         if (ev_q.size() == 0) begin
            check_output("unexpected_event", 1, 0);
         end else begin
            mon_ev = ev_q.pop_front();
            check_output("event_cycle", cycle, mon_ev.cyc);
            check_output("hi_write",    int'(bus.hi_write),    int'(mon_ev.kind == EV_WRITE));
            check_output("lo_write",    int'(bus.lo_write),    int'(mon_ev.kind == EV_WRITE));
            check_output("op_done",     int'(bus.op_done),     int'(mon_ev.kind == EV_WRITE));
            check_output("div0_exc",    int'(bus.div0_exc),    int'(mon_ev.kind == EV_DIV0));
            check_output("timeout_exc", int'(bus.timeout_exc), int'(mon_ev.kind == EV_TIMEOUT));
            check_output("mordhi_sel",  int'(bus.mordhi_sel),  int'(mon_ev.sel));
            check_output("mordlo_sel",  int'(bus.mordlo_sel),  int'(mon_ev.sel));
         end
      end
      if (bus.mult_start || bus.div_start) begin
         if (launch_q.size() == 0) begin
            check_output("unexpected_launch", 1, 0);
         end else begin
            mon_ln = launch_q.pop_front();
            check_output("launch_cycle", cycle, mon_ln.cyc);
            check_output("mult_start",   int'(bus.mult_start), int'(!mon_ln.is_div));
            check_output("div_start",    int'(bus.div_start),  int'(mon_ln.is_div));
         end
      end
      if (bus.busy) begin
         mon_busy_len++;
      end else if (mon_busy_len > 0) begin
         if (busy_q.size() == 0) begin
            check_output("unexpected_busy", mon_busy_len, 0);
         end else begin
            mon_busy_exp = busy_q.pop_front();
            check_output("busy_length", mon_busy_len, mon_busy_exp);
         end
         mon_busy_len = 0;
      end
   end

   // Main sequence: directed cases first, then a random mix
   initial begin
      int s;
      int kind;
      int n;
      int r;

      vectors        = 0;
      miscompares    = 0;
      reset          = 1'b0;
      bus.start_mult = 1'b0;
      bus.start_div  = 1'b0;
      bus.divisor    = 32'd0;
      bus.mult_done  = 1'b0;
      bus.div_done   = 1'b0;

      repeat (3) next_cycle();
      check_all_zero("reset");
      reset = 1'b1;

      apply_stimulus(0, 32, 1'b0);
      next_cycle();
      apply_stimulus(1, 4, 1'b0);
      apply_stimulus(2, 0, 1'b0);
      apply_stimulus(0, TIMEOUT, 1'b0);
      apply_stimulus(0, TIMEOUT - 1, 1'b0);
      apply_stimulus(3, 5, 1'b0);
      apply_stimulus(0, 6, 1'b1);
      apply_stimulus(1, 6, 1'b1);
      apply_stimulus(1, TIMEOUT, 1'b1);
      apply_stimulus(0, 0, 1'b0);
      apply_stimulus(1, 0, 1'b0);

      // Reset in the middle of a mult: nothing may be written afterwards
      next_cycle();
      s = cycle;
      begin
         launch_t ln;
         ln.is_div = 1'b0;
         ln.cyc    = s + 1;
         launch_q.push_back(ln);
         busy_q.push_back(9);
      end
      bus.start_mult = 1'b1;
      next_cycle();
      bus.start_mult = 1'b0;
      while (cycle < s + 10) next_cycle();
      reset = 1'b0;
      #1;
      check_all_zero("midrun_reset");
      next_cycle();
      bus.mult_done = 1'b1;
      next_cycle();
      bus.mult_done = 1'b0;
      next_cycle();
      reset = 1'b1;
      next_cycle();
      bus.mult_done = 1'b1;
      next_cycle();
      bus.mult_done = 1'b0;
      apply_stimulus(0, 3, 1'b0);

      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 3);
         r    = $urandom_range(0, 9);
         if (r < 7)       n = $urandom_range(0, 10);
         else if (r == 7) n = TIMEOUT - 1;
         else if (r == 8) n = TIMEOUT - 2;
         else             n = TIMEOUT + $urandom_range(0, 5);
         apply_stimulus(kind, n, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) next_cycle();
      end

      repeat (5) next_cycle();
      check_output("pending_events",   ev_q.size(),     0);
      check_output("pending_launches", launch_q.size(), 0);
      check_output("pending_busy",     busy_q.size(),   0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
